// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequence arbiter: shift-core
// mode encodings, FSM state enum, command record and a small helper.
package shift_seq_pkg;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 4;
  localparam int CNT_W   = 3;
  // Bits needed to index the serial pattern (k mod WIDTH).
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    LOAD  = 2'b10,
    HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_e;

  // Command fields captured from the winning requester at grant time.
  typedef struct packed {
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sin;
  } cmd_t;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
    id_to_onehot     = '0;
    id_to_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/shift_seq_arbiter_if.sv
// Request/result bundle between the requesters (master) and the
// shift sequence arbiter (slave).
interface shift_seq_arbiter_if;
  import shift_seq_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       dir;
  logic [NUM_REQ*CNT_W-1:0] cnt;
  logic [NUM_REQ*WIDTH-1:0] sin;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     done;
  logic                     done_id;
  logic [WIDTH-1:0]         result;

  modport master (
    output req, dir, cnt, sin,
    input  grant, busy, done, done_id, result
  );

  modport slave (
    input  req, dir, cnt, sin,
    output grant, busy, done, done_id, result
  );

endinterface

// File: rtl/shift_core.sv
// 4-bit shift register with load / shift-left / shift-right / hold modes.
module shift_core
  import shift_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  mode_e            mode,
  input  logic             data_in,
  output logic [WIDTH-1:0] q
);

  // Register update selected by mode; HOLD keeps the current contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (mode)
        LOAD:    q <= {{(WIDTH-1){1'b0}}, data_in};
        LEFT:    q <= {q[WIDTH-2:0], data_in};
        RIGHT:   q <= {data_in, q[WIDTH-1:1]};
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_arbiter.sv
// Two-requester arbiter owning a shared 4-bit shift datapath. The winner's
// direction, count and serial pattern are captured at grant; the register is
// cleared, shifted cnt times and the result is presented with a done pulse.
// Build option: define SHIFT_SEQ_RR_EN for round-robin arbitration; without
// it requester 0 has fixed priority and no pointer register exists.
module shift_seq_arbiter
  import shift_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  shift_seq_arbiter_if.slave  bus
);

  state_e           state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic             busy_q;
  logic             done_q;
  logic             done_id_q;
  logic             owner_q;
  cmd_t             cmd_q;
  logic [CNT_W-1:0] k_q;

  logic             winner_d;
  cmd_t             cmd_d;
  cmd_t             req_cmd [NUM_REQ];

  mode_e            core_mode;
  logic             core_din;
  logic [WIDTH-1:0] core_q;

  // Per-requester command slices of the flat input buses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
    assign req_cmd[gi] = '{dir: bus.dir[gi],
                           cnt: bus.cnt[gi*CNT_W +: CNT_W],
                           sin: bus.sin[gi*WIDTH +: WIDTH]};
  end

`ifdef SHIFT_SEQ_RR_EN
  logic rr_ptr_q;

  // Round-robin: on a tie the favoured requester wins, otherwise the lone one.
  always_comb begin
    winner_d = bus.req[1];
    if (bus.req == 2'b11) begin
      winner_d = rr_ptr_q;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it asks.
  assign winner_d = ~bus.req[0];
`endif

  assign cmd_d = req_cmd[winner_d];

  // Core control: clear in CLEAR, shift in SHIFT, hold everywhere else.
  always_comb begin
    core_mode = HOLD;
    core_din  = 1'b0;
    case (state_q)
      CLEAR: begin
        core_mode = LOAD;
        core_din  = 1'b0;
      end
      SHIFT: begin
        core_mode = cmd_q.dir ? RIGHT : LEFT;
        core_din  = cmd_q.sin[k_q[IDX_W-1:0]];
      end
      default: begin
        core_mode = HOLD;
        core_din  = 1'b0;
      end
    endcase
  end

  // Operation sequencer with registered grant/busy/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      owner_q   <= 1'b0;
      cmd_q     <= '0;
      k_q       <= '0;
`ifdef SHIFT_SEQ_RR_EN
      rr_ptr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= CLEAR;
            grant_q <= id_to_onehot(winner_d);
            busy_q  <= 1'b1;
            owner_q <= winner_d;
            cmd_q   <= cmd_d;
          end
        end
        CLEAR: begin
          k_q <= '0;
          if (cmd_q.cnt != '0) begin
            state_q <= SHIFT;
          end else begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            done_id_q <= owner_q;
          end
        end
        SHIFT: begin
          if (k_q == cmd_q.cnt - CNT_W'(1)) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            done_id_q <= owner_q;
          end else begin
            k_q <= k_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
`ifdef SHIFT_SEQ_RR_EN
          // Favour the other requester next time.
          rr_ptr_q <= ~owner_q;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  shift_core u_core (
    .clk     (clk),
    .reset   (reset),
    .mode    (core_mode),
    .data_in (core_din),
    .q       (core_q)
  );

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.result  = core_q;

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// Self-checking bench for shift_seq_arbiter: directed table, hand-written
// arbitration and reset sequences, then randomized operations against a
// transaction-level model.
module tb_shift_seq_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shift_seq_arbiter_if bus ();

  shift_seq_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int fav    = 0;   // requester favoured on a tie (round-robin build only)

  typedef struct {
    logic [1:0] req;
    logic [1:0] dir;
    logic [5:0] cnt;
    logic [7:0] sin;
    logic [1:0] exp_grant;
    int         exp_id;
    logic [3:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result of cnt serial inserts into a cleared 4-bit register.
  function automatic int model_result(input int dir, input int cnt, input int sin);
    int r = 0;
    for (int k = 0; k < cnt; k++) begin
      int b = (sin >> (k % 4)) & 1;
      if (dir == 0) r = ((r << 1) | b) & 15;
      else          r = (r >> 1) | (b << 3);
    end
    return r;
  endfunction

  function automatic int model_winner(input int req);
`ifdef SHIFT_SEQ_RR_EN
    if (req == 3) return fav;
`endif
    if ((req & 1) != 0) return 0;
    return 1;
  endfunction

  // Starts an operation in an IDLE cycle and checks it cycle by cycle.
  task automatic run_op(input logic [1:0] req, input logic [1:0] dir,
                        input logic [5:0] cnt, input logic [7:0] sin,
                        input bit scramble, input logic [1:0] exp_grant,
                        input int exp_id, input logic [3:0] exp_res,
                        input int exp_lat);
    logic [3:0] got_res;
    bus.req = req; bus.dir = dir; bus.cnt = cnt; bus.sin = sin;
    @(posedge clk); #1;
    check("grant", bus.grant, exp_grant);
    check("busy", bus.busy, 1);
    if (scramble) begin
      bus.req = 2'($urandom); bus.dir = 2'($urandom);
      bus.cnt = 6'($urandom); bus.sin = 8'($urandom);
    end
    got_res = 'x;
    for (int c = 2; c <= exp_lat; c++) begin
      @(posedge clk); #1;
      if (c < exp_lat) begin
        check("early_done", bus.done, 0);
        check("busy_hold", bus.busy, 1);
      end else begin
        got_res = bus.result;
        check("done", bus.done, 1);
        check("done_id", bus.done_id, exp_id);
        check("result", bus.result, exp_res);
      end
    end
    @(posedge clk); #1;
    check("grant_release", bus.grant, 0);
    check("busy_release", bus.busy, 0);
    check("done_pulse", bus.done, 0);
    bus.req = 2'b00;
    fav = 1 - exp_id;
    $display("op req=%b grant=%b id=%0d result=%b lat=%0d", req, exp_grant, exp_id, got_res, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'b01, 2'b00, 6'o03, 8'h05, 2'b01, 0, 4'b0101, 5};
    tbl[1] = '{2'b10, 2'b10, 6'o20, 8'h30, 2'b10, 1, 4'b1100, 4};
    tbl[2] = '{2'b01, 2'b00, 6'o00, 8'hFF, 2'b01, 0, 4'b0000, 2};
    tbl[3] = '{2'b01, 2'b00, 6'o07, 8'h0B, 2'b01, 0, 4'b1110, 9};
    tbl[4] = '{2'b10, 2'b10, 6'o40, 8'hA0, 2'b10, 1, 4'b1010, 6};
    tbl[5] = '{2'b01, 2'b00, 6'o05, 8'h06, 2'b01, 0, 4'b1100, 7};

    reset = 1'b1;
    bus.req = '0; bus.dir = '0; bus.cnt = '0; bus.sin = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_done_id", bus.done_id, 0);
    check("rst_result", bus.result, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    fav = 0;

    // Both requesting across two operations.
    run_op(2'b11, 2'b10, 6'o11, 8'h11, 1'b0, 2'b01, 0, 4'b0001, 3);
`ifdef SHIFT_SEQ_RR_EN
    run_op(2'b11, 2'b10, 6'o11, 8'h11, 1'b0, 2'b10, 1, 4'b1000, 3);
`else
    run_op(2'b11, 2'b10, 6'o11, 8'h11, 1'b0, 2'b01, 0, 4'b0001, 3);
`endif

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].req, tbl[i].dir, tbl[i].cnt, tbl[i].sin, bit'(i % 2),
             tbl[i].exp_grant, tbl[i].exp_id, tbl[i].exp_res, tbl[i].exp_lat);
    end

    // Reset in the middle of a shift sequence.
    bus.req = 2'b10; bus.dir = 2'b00; bus.cnt = 6'o70; bus.sin = 8'hF0;
    @(posedge clk); #1;
    check("mid_grant", bus.grant, 2'b10);
    bus.req = 2'b00;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_result", bus.result, 0);
    @(posedge clk); #3 reset = 1'b0;
    fav = 0;
    @(posedge clk); #1;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_grant", bus.grant, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", bus.done, 0);
    end
    $display("op reset-abort checked");

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] r;
      logic [1:0] d;
      logic [5:0] c;
      logic [7:0] s;
      int w;
      int wc;
      r = 2'($urandom_range(1, 3));
      d = 2'($urandom);
      c = 6'($urandom);
      s = 8'($urandom);
      w  = model_winner(int'(r));
      wc = (int'(c) >> (3 * w)) & 7;
      run_op(r, d, c, s, bit'($urandom_range(0, 1)), 2'(1 << w), w,
             4'(model_result((int'(d) >> w) & 1, wc, (int'(s) >> (4 * w)) & 15)),
             wc + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq_arbiter.md
SHIFT_SEQ_ARBITER -- requirements
Module: shift_seq_arbiter

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-requester operation request; bit i belongs to requester i.
REQ-005 dir  input  2  per-requester shift direction: 0 = left (insert at LSB), 1 = right (insert at MSB).
REQ-006 cnt  input  6  per-requester shift count; cnt[3i+2:3i] is requester i, range 0..7.
REQ-007 sin  input  8  per-requester serial pattern; sin[4i+3:4i] is requester i.
REQ-008 grant  output  2  one-hot owner of the shift datapath; all zero when idle.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 done_id  output  1  index of the requester whose operation completed; valid with done.
REQ-012 result  output  4  shift register contents; valid while done=1.

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, SHIFT and DONE, and it SHALL reset to IDLE.
REQ-014 IDLE with any req bit set -> winner chosen per REQ-020/REQ-026; grant registered; next state CLEAR.
REQ-015 CLEAR (1 cycle): core mode LOAD with serial bit 0 -> register = 4'b0000; next state SHIFT if the latched cnt > 0, else DONE.
REQ-016 SHIFT: exactly cnt cycles; shift k (k = 0..cnt-1) SHALL insert sin[4i + (k mod 4)] with mode LEFT or RIGHT per the latched dir; after the last shift, next state DONE.
REQ-017 DONE (1 cycle): done=1, done_id=i, result = register; next state IDLE; grant is released on entry to IDLE.
REQ-018 dir, cnt and sin of the winner SHALL be latched at grant; input changes during the operation SHALL be ignored.
REQ-019 Deasserting req mid-operation SHALL NOT abort the operation; it completes normally.
REQ-020 Simultaneous requests SHALL be resolved by round-robin: the requester not served last wins; the pointer updates in DONE.
REQ-021 Latency from req sampled in IDLE at cycle N: grant at N+1, done at N+2+cnt; the next grant is no earlier than N+3+cnt.
REQ-022 The core mode SHALL be HOLD in IDLE and DONE; the register SHALL retain its value until the next CLEAR.

Reset
REQ-023 On reset the block SHALL set state=IDLE, grant=00, busy=0, done=0, done_id=0, result=0000, register=0000, RR pointer=0 (requester 0 favoured), and clear all latched command fields.
REQ-024 Reset asserted mid-operation SHALL abandon the operation without a done pulse; after reset release, the block SHALL sample requests afresh in IDLE.

Configuration
REQ-025 The macro SHIFT_SEQ_RR_EN, when defined, SHALL enable round-robin arbitration per REQ-020.
REQ-026 When SHIFT_SEQ_RR_EN is undefined, arbitration SHALL be fixed priority with requester 0 winning, and no pointer register SHALL be built.

Structure
REQ-027 The package shift_seq_pkg SHALL hold the mode encodings (LEFT=2'b00, RIGHT=2'b01, LOAD=2'b10, HOLD=2'b11), the FSM state enum, and constants NUM_REQ=2, WIDTH=4, CNT_W=3.
REQ-028 The 4-bit register SHALL be a sub-module shift_core (clk, reset, mode, data_in, q) with these operations: LOAD gives {3'b000, data_in}, LEFT gives {q[2:0], data_in}, RIGHT gives {data_in, q[3:1]}, HOLD keeps q.

Verification
REQ-029 req=01, dir0=0, cnt0=3, sin0=0101 -> grant=01 at N+1; done at N+5 with done_id=0 and result=0101.
REQ-030 req=10, dir1=1, cnt1=2, sin1=0011 -> done at N+4 with done_id=1 and result=1100.
REQ-031 req=01, cnt0=0 -> CLEAR then DONE; done at N+2 with result=0000.
REQ-032 req=01, dir0=0, cnt0=7, sin0=1011 -> done at N+9 with result=1110 (pattern index wraps mod 4).
REQ-033 req=11 held across two operations with SHIFT_SEQ_RR_EN defined -> grants go 01 then 10; with the macro undefined -> grants go 01 then 01.
REQ-034 reset pulsed during SHIFT -> no done pulse, all outputs zero, and the block is back in IDLE on the next edge.
